// File: rtl/ppu_ctrl_pkg.sv
// Shared types and constants for the PPU control commit scheduler.
package ppu_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StSync,
    StDone
  } commit_state_e;

  localparam logic [1:0] PPU_REG_BGSCROLL = 2'd0;
  localparam logic [1:0] PPU_REG_FGSCROLL = 2'd1;
  localparam logic [1:0] PPU_REG_ENABLE   = 2'd2;
  localparam logic [1:0] PPU_REG_BGCOLOR  = 2'd3;

  localparam logic [31:0] BGSCROLL_RST = 32'h0001_0000;
  localparam logic [31:0] FGSCROLL_RST = 32'h0000_0000;
  localparam logic [2:0]  ENABLE_RST   = 3'b111;
  localparam logic [23:0] BGCOLOR_RST  = 24'h00_0000;

endpackage

// File: rtl/ppu_ctrl_commit_sched.sv
// CPU-side staging of PPU control registers; schedules the vblank-aligned sync strobe
// that copies them into the double-buffered PPU registers.
module ppu_ctrl_commit_sched
  import ppu_ctrl_pkg::*;
#(
  parameter bit          AUTO_SYNC   = 1'b0,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vblank_start,
  input  logic                   wr_en,
  input  logic [1:0]             wr_addr,
  input  logic [31:0]            wr_data,
  output logic                   wr_ready,
  input  logic                   commit_valid,
  output logic                   commit_ready,
  output logic                   commit_done,
  output logic                   commit_pending,
  output logic [31:0]            ppu_bgscroll,
  output logic [31:0]            ppu_fgscroll,
  output logic [2:0]             ppu_enable,
  output logic [23:0]            ppu_bgcolor,
  output logic                   sync,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  commit_state_e state_q, state_d;

  logic [31:0]            bgscroll_q, fgscroll_q;
  logic [2:0]             enable_q;
  logic [23:0]            bgcolor_q;
  logic                   sync_q, done_q, pending_q;
  logic [FRAME_CNT_W-1:0] frame_q;
  logic                   wr_accept;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (commit_valid) state_d = StPending;
      // A vblank coinciding with acceptance is seen in StIdle, so that commit waits a frame.
      StPending: if (vblank_start) state_d = StSync;
      StSync:    state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign wr_ready     = (state_q == StIdle);
  assign commit_ready = (state_q == StIdle);
  assign wr_accept    = wr_en && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sync_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
      frame_q   <= '0;
    end else begin
      state_q   <= state_d;
      // Auto mode strobes on every vblank without walking the handshake FSM.
      sync_q    <= (state_d == StSync) || (AUTO_SYNC && vblank_start);
      done_q    <= (state_d == StDone);
      pending_q <= (state_d == StPending) || (state_d == StSync);
      if (vblank_start) frame_q <= frame_q + FRAME_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bgscroll_q <= BGSCROLL_RST;
      fgscroll_q <= FGSCROLL_RST;
      enable_q   <= ENABLE_RST;
      bgcolor_q  <= BGCOLOR_RST;
    end else if (wr_accept) begin
      unique case (wr_addr)
        PPU_REG_BGSCROLL: bgscroll_q <= wr_data;
        PPU_REG_FGSCROLL: fgscroll_q <= wr_data;
        PPU_REG_ENABLE:   enable_q   <= wr_data[2:0];
        PPU_REG_BGCOLOR:  bgcolor_q  <= wr_data[23:0];
        default:          ;
      endcase
    end
  end

  assign ppu_bgscroll   = bgscroll_q;
  assign ppu_fgscroll   = fgscroll_q;
  assign ppu_enable     = enable_q;
  assign ppu_bgcolor    = bgcolor_q;
  assign sync           = sync_q;
  assign commit_done    = done_q;
  assign commit_pending = pending_q;
  assign frame_count    = frame_q;

endmodule

// File: tb/tb_ppu_ctrl_commit_sched.sv
// Directed bench for ppu_ctrl_commit_sched: sync/commit_done events are checked against a
// queue of expected events, with level checks on staging and handshake outputs.
module tb_ppu_ctrl_commit_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic vblank_start, wr_en, commit_valid;
  logic [1:0] wr_addr;
  logic [31:0] wr_data;
  logic wr_ready, commit_ready, commit_done, commit_pending, sync;
  logic [31:0] ppu_bgscroll, ppu_fgscroll;
  logic [2:0] ppu_enable;
  logic [23:0] ppu_bgcolor;
  logic [15:0] frame_count;

  logic a_vblank, a_wr_en, a_commit_valid;
  logic [1:0] a_wr_addr;
  logic [31:0] a_wr_data;
  logic a_wr_ready, a_commit_ready, a_commit_done, a_commit_pending, a_sync;
  logic [31:0] a_bgscroll, a_fgscroll;
  logic [2:0] a_enable;
  logic [23:0] a_bgcolor;
  logic [3:0] a_frame_count;

  ppu_ctrl_commit_sched dut (
    .clk(clk), .rst_n(rst_n), .vblank_start(vblank_start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_done(commit_done),
    .commit_pending(commit_pending), .ppu_bgscroll(ppu_bgscroll),
    .ppu_fgscroll(ppu_fgscroll), .ppu_enable(ppu_enable), .ppu_bgcolor(ppu_bgcolor),
    .sync(sync), .frame_count(frame_count)
  );

  ppu_ctrl_commit_sched #(.AUTO_SYNC(1'b1), .FRAME_CNT_W(4)) dut_auto (
    .clk(clk), .rst_n(rst_n), .vblank_start(a_vblank), .wr_en(a_wr_en),
    .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
    .commit_valid(a_commit_valid), .commit_ready(a_commit_ready),
    .commit_done(a_commit_done), .commit_pending(a_commit_pending),
    .ppu_bgscroll(a_bgscroll), .ppu_fgscroll(a_fgscroll), .ppu_enable(a_enable),
    .ppu_bgcolor(a_bgcolor), .sync(a_sync), .frame_count(a_frame_count)
  );

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [23:0] bgcolor;
    logic [31:0] bgscroll;
  } exp_t;

  exp_t exp_q[$];
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_done, input int c, input logic [23:0] bgc,
                      input logic [31:0] bgs);
    exp_t e;
    e.is_done = is_done;
    e.cyc = c;
    e.bgcolor = bgc;
    e.bgscroll = bgs;
    exp_q.push_back(e);
  endtask

  task automatic write(input logic [1:0] addr, input logic [31:0] data);
    wr_en = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Monitor: every sync / commit_done pulse must match the next expected event.
  always @(negedge clk) begin
    exp_t e;
    if (sync || commit_done) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_event: got sync=%0b done=%0b expected none (cycle %0d)",
                 sync, commit_done, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_done", {31'b0, commit_done}, {31'b0, e.is_done});
        check("event_cycle", cyc, e.cyc);
        if (!e.is_done) begin
          check("sync_bgcolor", {8'b0, ppu_bgcolor}, {8'b0, e.bgcolor});
          check("sync_bgscroll", ppu_bgscroll, e.bgscroll);
        end
      end
    end
  end

  int n;

  initial begin
    rst_n = 1'b0;
    vblank_start = 0; wr_en = 0; commit_valid = 0; wr_addr = 0; wr_data = 0;
    a_vblank = 0; a_wr_en = 0; a_commit_valid = 0; a_wr_addr = 0; a_wr_data = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset values and idle handshake.
    check("rst_bgscroll", ppu_bgscroll, 32'h0001_0000);
    check("rst_fgscroll", ppu_fgscroll, 32'h0);
    check("rst_enable", {29'b0, ppu_enable}, 32'h7);
    check("rst_bgcolor", {8'b0, ppu_bgcolor}, 32'h0);
    check("rst_sync", {31'b0, sync}, 32'h0);
    check("rst_frame_count", {16'b0, frame_count}, 32'h0);
    check("rst_ready", {30'b0, wr_ready, commit_ready}, 32'h3);
    check("rst_pending", {31'b0, commit_pending}, 32'h0);

    // Vblanks with no commit: count only, no sync.
    for (int i = 0; i < 3; i++) begin
      vblank_start = 1; tick(); vblank_start = 0; tick();
    end
    check("frame_count_3", {16'b0, frame_count}, 32'd3);

    // Staging writes; unused upper bits are dropped.
    write(2'd3, 32'hFFAB_CDEF);
    check("wr_bgcolor", {8'b0, ppu_bgcolor}, 32'h00AB_CDEF);
    write(2'd2, 32'hFFFF_FFF5);
    check("wr_enable", {29'b0, ppu_enable}, 32'h5);
    write(2'd1, 32'hDEAD_BEEF);
    check("wr_fgscroll", ppu_fgscroll, 32'hDEAD_BEEF);

    // Basic commit: sync at N+1, done at N+2.
    commit_valid = 1; tick(); commit_valid = 0;
    check("pend_pending", {31'b0, commit_pending}, 32'h1);
    check("pend_ready", {30'b0, wr_ready, commit_ready}, 32'h0);
    tick(); tick();
    n = cyc;
    push(1'b0, n + 1, 24'hABCDEF, 32'h0001_0000);
    push(1'b1, n + 2, 24'h0, 32'h0);
    vblank_start = 1; tick(); vblank_start = 0;
    check("sync_pending", {31'b0, commit_pending}, 32'h1);
    tick();
    check("done_pending", {31'b0, commit_pending}, 32'h0);
    check("done_wr_ready", {31'b0, wr_ready}, 32'h0);
    tick();
    check("idle_wr_ready", {31'b0, wr_ready}, 32'h1);

    // Write held during PENDING is accepted only after DONE.
    commit_valid = 1; tick(); commit_valid = 0;
    wr_en = 1; wr_addr = 2'd0; wr_data = 32'h1234;
    check("pend_write_ready", {31'b0, wr_ready}, 32'h0);
    tick();
    check("pend_write_dropped", ppu_bgscroll, 32'h0001_0000);
    n = cyc;
    push(1'b0, n + 1, 24'hABCDEF, 32'h0001_0000);
    push(1'b1, n + 2, 24'h0, 32'h0);
    vblank_start = 1; tick(); vblank_start = 0;
    tick();
    check("done_write_dropped", ppu_bgscroll, 32'h0001_0000);
    tick();
    check("post_done_ready", {31'b0, wr_ready}, 32'h1);
    check("post_done_not_yet", ppu_bgscroll, 32'h0001_0000);
    tick(); wr_en = 0;
    check("held_write_landed", ppu_bgscroll, 32'h0000_1234);

    // Commit accepted on a vblank cycle waits for the following vblank.
    commit_valid = 1; vblank_start = 1; tick(); commit_valid = 0; vblank_start = 0;
    tick(); tick(); tick();
    check("same_cycle_still_pending", {31'b0, commit_pending}, 32'h1);
    n = cyc;
    push(1'b0, n + 1, 24'hABCDEF, 32'h0000_1234);
    push(1'b1, n + 2, 24'h0, 32'h0);
    vblank_start = 1; tick(); vblank_start = 0;
    tick(); tick();
    check("frame_count_7", {16'b0, frame_count}, 32'd7);
    check("same_cycle_done_pending", {31'b0, commit_pending}, 32'h0);

    // Reset during PENDING: no sync afterwards, staging restored.
    write(2'd1, 32'h55);
    commit_valid = 1; tick(); commit_valid = 0;
    check("pre_rst_pending", {31'b0, commit_pending}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pending", {31'b0, commit_pending}, 32'h0);
    check("mid_rst_fgscroll", ppu_fgscroll, 32'h0);
    check("mid_rst_bgscroll", ppu_bgscroll, 32'h0001_0000);
    check("mid_rst_enable", {29'b0, ppu_enable}, 32'h7);
    check("mid_rst_commit_ready", {31'b0, commit_ready}, 32'h1);
    tick(); rst_n = 1'b1; tick();
    vblank_start = 1; tick(); vblank_start = 0;
    tick(); tick();
    check("post_rst_pending", {31'b0, commit_pending}, 32'h0);
    check("post_rst_frame_count", {16'b0, frame_count}, 32'd1);

    // AUTO_SYNC instance: sync on idle vblank, writes not blocked, 4-bit wrap.
    a_vblank = 1; tick(); a_vblank = 0;
    a_wr_en = 1; a_wr_addr = 2'd3; a_wr_data = 32'h0011_2233;
    check("auto_sync", {31'b0, a_sync}, 32'h1);
    check("auto_no_done", {31'b0, a_commit_done}, 32'h0);
    check("auto_ready", {30'b0, a_wr_ready, a_commit_ready}, 32'h3);
    check("auto_sync_bgcolor_old", {8'b0, a_bgcolor}, 32'h0);
    tick(); a_wr_en = 0;
    check("auto_sync_low", {31'b0, a_sync}, 32'h0);
    check("auto_write_landed", {8'b0, a_bgcolor}, 32'h0011_2233);
    check("auto_no_pending", {31'b0, a_commit_pending}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      a_vblank = 1; tick(); a_vblank = 0; tick();
    end
    check("auto_frame_wrap", {28'b0, a_frame_count}, 32'd1);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ppu_ctrl_commit_sched.md
Name: ppu_ctrl_commit_sched

Overview:
- Owns the CPU-side staging copies of the PPU control registers: bgscroll, fgscroll, enable and bgcolor.
- Schedules the single-cycle `sync` pulse that copies the staged values into the double-buffered PPU control registers.
- Sits between the HPS/MMIO register-write path and the double-buffer stage. The commit lands only at the start of vertical blanking, so the PPU never sees a mid-frame control change.
- Also provides a commit handshake and a free-running frame counter to software.

Parameters:
- AUTO_SYNC, 0: when 1, `sync` fires on every vblank_start whether or not a commit is requested. The handshake still operates.
- FRAME_CNT_W, 16: width of frame_count.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- vblank_start  input  1  one-cycle pulse from video timing at the first vblank line
- wr_en  input  1  staging-register write strobe
- wr_addr  input  2  0=bgscroll, 1=fgscroll, 2=enable, 3=bgcolor
- wr_data  input  32  write data (enable uses [2:0], bgcolor uses [23:0])
- wr_ready  output  1  staging writes accepted this cycle
- commit_valid  input  1  software requests a commit
- commit_ready  output  1  commit request accepted when valid&&ready
- commit_done  output  1  one-cycle pulse, cycle after sync
- commit_pending  output  1  a commit is accepted but not yet synced
- ppu_bgscroll  output  32  staged bgscroll
- ppu_fgscroll  output  32  staged fgscroll
- ppu_enable  output  3  staged enable
- ppu_bgcolor  output  24  staged bgcolor
- sync  output  1  one-cycle latch strobe to the double-buffer stage
- frame_count  output  FRAME_CNT_W  count of vblank_start pulses since reset

Behaviour:
- Reset values (async on rst_n low):
  - ppu_bgscroll = 32'h0001_0000, ppu_fgscroll = 0, ppu_enable = 3'b111, ppu_bgcolor = 24'h000000.
  - sync = 0, commit_done = 0, frame_count = 0, state = IDLE.
- FSM states:
  - IDLE: wr_ready=1, commit_ready=1, commit_pending=0.
    - commit_valid -> PENDING on the next cycle.
  - PENDING: wr_ready=0, commit_ready=0, commit_pending=1.
    - vblank_start -> SYNC on the next cycle.
  - SYNC: sync=1 for exactly this cycle. wr_ready=0, commit_pending=1. Unconditionally -> DONE.
  - DONE: commit_done=1 for exactly this cycle. wr_ready=0. -> IDLE.
- Latency: commit_done rises exactly 2 cycles after the accepting vblank_start (vblank_start at cycle N: SYNC at N+1, DONE at N+2).
- A vblank_start in the same cycle a commit is accepted does NOT trigger that commit. The commit waits for the next vblank_start.
- Staging writes:
  - Registered, taking effect the cycle after wr_en&&wr_ready.
  - Upper unused bits of wr_data are ignored.
  - A write while wr_ready=0 is dropped; the master must hold it.
- A write and a commit_valid in the same IDLE cycle: the write is accepted and its value is part of that commit.
- AUTO_SYNC=1:
  - In IDLE, vblank_start produces sync the next cycle with no FSM transition and no commit_done.
  - Staging writes are not blocked during that sync cycle. A write landing in the sync cycle is not captured until the next frame.
  - PENDING behaves as above.
- frame_count increments on every vblank_start in all states and wraps modulo 2^FRAME_CNT_W.
- All outputs are registered; no combinational input-to-output paths except wr_ready and commit_ready, which are decoded from state.
- Reset mid-commit: returns to IDLE and restores the staging reset values. No sync or commit_done is emitted.

Decomposition:
- Package ppu_ctrl_pkg holds:
  - the commit FSM state enum;
  - wr_addr decode constants (PPU_REG_BGSCROLL=0 … PPU_REG_BGCOLOR=3);
  - staging reset-value constants.
- No sub-module is needed. The FSM, staging register file and frame counter live in one module.
- At top level, sync feeds the double-buffer stage's sync input and ppu_* feed its data inputs.

Test Plan:
- Reset release, no activity -> staging outputs hold reset values, sync=0; 3 vblank_start pulses -> frame_count=3, no sync (AUTO_SYNC=0).
- Write bgcolor=32'h00ABCDEF, pulse commit_valid, vblank_start at cycle N -> ppu_bgcolor=24'hABCDEF; sync high only at N+1; commit_done high only at N+2; commit_pending high from acceptance through N+1.
- In PENDING, assert wr_en addr 0 data 32'h1234 -> wr_ready=0, ppu_bgscroll unchanged; the write is accepted on the first IDLE cycle after DONE.
- Accept commit in the same cycle as vblank_start -> no sync that frame; sync one cycle after the following vblank_start.
- AUTO_SYNC=1: vblank_start in IDLE -> sync next cycle, commit_done=0, FSM stays IDLE; FRAME_CNT_W=4 with 17 pulses -> frame_count=1.
- rst_n asserted during PENDING -> state IDLE, commit_pending=0, no sync on the next vblank_start, staging back to reset values.
